food_spawn_ctrl: RTL and testbench

Hardware sequencer for the game's 20-bit random food coordinate. It replaces software writes to the coordinate PIO with an LFSR-driven generate/check/publish loop. Spawn requests come from two players and from the CPU. Each candidate is range-checked against the playfield and checked against a snake-occupancy lookup, and only a free cell is published. Sits between the player logic, the occupancy RAM and the VGA/food renderer, with an Avalon-MM slave for CPU control.

---
 rtl/food_spawn_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_food_spawn_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_spawn_ctrl.sv
// rtl/food_spawn_ctrl.sv - LFSR food coordinate generate/check/publish sequencer; optional irq under SPAWN_IRQ_EN
module food_spawn_ctrl #(
    parameter logic [9:0] X_MAX     = 10'd640,
    parameter logic [9:0] Y_MAX     = 10'd480,
    parameter logic [7:0] MAX_RETRY = 8'd64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_write_n,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    input  logic [1:0]  spawn_req,
    output logic [1:0]  spawn_grant,
    output logic        occ_req,
    output logic [9:0]  occ_x,
    output logic [9:0]  occ_y,
    input  logic        occ_ack,
    input  logic        occ_hit,
`ifdef SPAWN_IRQ_EN
    output logic        irq,
`endif
    output logic [19:0] coord_out,
    output logic        coord_valid
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_GEN     = 2'd1;
    localparam logic [1:0]  S_CHECK   = 2'd2;
    localparam logic [1:0]  S_PUB     = 2'd3;
    // Right-shifting Galois form of x^20 + x^17 + 1
    localparam logic [19:0] LFSR_TAPS = 20'h90000;

    logic [1:0]  state;
    logic [19:0] lfsr;
    logic [19:0] lfsr_next;
    logic [2:0]  pending;
    logic [2:0]  pick_clr;
    logic [2:0]  pend_clr;
    logic [7:0]  retry;
    logic [7:0]  retry_inc;
    logic [1:0]  winner;
    logic        last_served;
    logic        fail;
    logic        enable;

    logic        wr_en;
    logic        wr_ctrl;
    logic        wr_seed;
    logic        wr_status;
    logic        sw_trigger;
    logic [9:0]  cand_x;
    logic [9:0]  cand_y;
    logic        cand_in_range;
    logic        check_hit;
    logic        check_free;
    logic        reject;
    logic        give_up;
    logic        start;
    logic        irq_en_rd;
    logic        irq_rd;
    logic        unused_wdata;

    assign wr_en      = avs_chipselect & ~avs_write_n;
    assign wr_ctrl    = wr_en && (avs_address == 2'd0);
    assign wr_seed    = wr_en && (avs_address == 2'd1);
    assign wr_status  = wr_en && (avs_address == 2'd3);
    assign sw_trigger = wr_ctrl & avs_writedata[1];
    assign unused_wdata = ^{avs_writedata[31:20], avs_writedata[2]};

    assign cand_x        = lfsr[19:10];
    assign cand_y        = lfsr[9:0];
    assign cand_in_range = (cand_x < X_MAX) && (cand_y < Y_MAX);
    assign lfsr_next     = {1'b0, lfsr[19:1]} ^ (lfsr[0] ? LFSR_TAPS : 20'h00000);

    assign check_hit  = (state == S_CHECK) && occ_ack && occ_hit;
    assign check_free = (state == S_CHECK) && occ_ack && !occ_hit;
    assign reject     = ((state == S_GEN) && !cand_in_range) || check_hit;
    assign retry_inc  = retry + 8'd1;
    assign give_up    = reject && (retry_inc >= MAX_RETRY);
    assign start      = (state == S_IDLE) && enable && (pending != 3'b000);
    assign pend_clr   = start ? pick_clr : 3'b000;

    // Query stays up for the whole CHECK state so reset drops it with the state
    assign occ_req = (state == S_CHECK);

    // Winner selection: software trigger first, then the player not served last
    always_comb begin
        pick_clr = 3'b000;
        if (pending[2]) begin
            pick_clr = 3'b100;
        end else if (pending[1:0] == 2'b11) begin
            pick_clr = last_served ? 3'b001 : 3'b010;
        end else if (pending[0]) begin
            pick_clr = 3'b001;
        end else if (pending[1]) begin
            pick_clr = 3'b010;
        end
    end

    // CTRL enable bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b0;
        end else if (wr_ctrl) begin
            enable <= avs_writedata[0];
        end
    end

    // LFSR: a SEED write wins over the per-GEN-cycle advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= 20'h00001;
        end else if (wr_seed) begin
            lfsr <= (avs_writedata[19:0] == 20'h00000) ? 20'h00001 : avs_writedata[19:0];
        end else if (state == S_GEN) begin
            lfsr <= lfsr_next;
        end
    end

    // Pending requests accumulate every cycle; the winner's bit is consumed at start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 3'b000;
        end else begin
            pending <= (pending & ~pend_clr) | {sw_trigger, spawn_req};
        end
    end

    // Spawn sequencer: generate, occupancy check, publish or give up
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            retry       <= 8'd0;
            winner      <= 2'b00;
            last_served <= 1'b1;
            fail        <= 1'b0;
            occ_x       <= 10'd0;
            occ_y       <= 10'd0;
            coord_out   <= 20'd0;
            coord_valid <= 1'b0;
            spawn_grant <= 2'b00;
        end else begin
            coord_valid <= 1'b0;
            spawn_grant <= 2'b00;
            if (wr_status) begin
                fail <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        winner <= pick_clr[1:0];
                        if (!pick_clr[2]) begin
                            last_served <= pick_clr[1];
                        end
                        retry <= 8'd0;
                        state <= S_GEN;
                    end
                end
                S_GEN: begin
                    if (give_up) begin
                        fail        <= 1'b1;
                        retry       <= retry_inc;
                        spawn_grant <= winner;
                        state       <= S_IDLE;
                    end else if (!cand_in_range) begin
                        retry <= retry_inc;
                    end else begin
                        occ_x <= cand_x;
                        occ_y <= cand_y;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (give_up) begin
                        fail        <= 1'b1;
                        retry       <= retry_inc;
                        spawn_grant <= winner;
                        state       <= S_IDLE;
                    end else if (check_hit) begin
                        retry <= retry_inc;
                        state <= S_GEN;
                    end else if (check_free) begin
                        coord_out   <= {occ_x, occ_y};
                        coord_valid <= 1'b1;
                        spawn_grant <= winner;
                        state       <= S_PUB;
                    end
                end
                S_PUB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SPAWN_IRQ_EN
    logic irq_en;
    logic irq_q;

    assign irq       = irq_q;
    assign irq_en_rd = irq_en;
    assign irq_rd    = irq_q;

    // CTRL irq enable bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            irq_en <= avs_writedata[2];
        end
    end

    // Interrupt latches on publish or failure; a new event beats a STATUS write clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else if (irq_en && (check_free || give_up)) begin
            irq_q <= 1'b1;
        end else if (wr_status) begin
            irq_q <= 1'b0;
        end
    end
`else
    assign irq_en_rd = 1'b0;
    assign irq_rd    = 1'b0;
`endif

    // Zero-wait-state register read mux
    always_comb begin
        avs_readdata = 32'd0;
        case (avs_address)
            2'd0: avs_readdata = {29'd0, irq_en_rd, 1'b0, enable};
            2'd1: avs_readdata = {12'd0, lfsr};
            2'd2: avs_readdata = {12'd0, coord_out};
            2'd3: avs_readdata = {16'd0, retry, 3'd0, irq_rd, pending[1:0], fail, (state != S_IDLE)};
            default: avs_readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// tb/tb_food_spawn_ctrl.sv - directed self-checking bench for food_spawn_ctrl
module tb_food_spawn_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_chipselect = 1'b0;
    logic        avs_write_n = 1'b1;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic [1:0]  spawn_req = 2'b00;
    logic [1:0]  spawn_grant;
    logic        occ_req;
    logic [9:0]  occ_x;
    logic [9:0]  occ_y;
    logic        occ_ack;
    logic        occ_hit;
    logic [19:0] coord_out;
    logic        coord_valid;

    logic        ack_tie = 1'b1;
    logic        ack_man = 1'b0;
    logic        hit_all = 1'b0;
    logic        cnt_clr = 1'b0;
    int          hit_n = 0;
    int          ack_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic [19:0] last_coord = 20'd0;

    always #5 clk = ~clk;

    assign occ_ack = ack_tie ? occ_req : ack_man;
    assign occ_hit = hit_all | (ack_cnt < hit_n);

    always @(posedge clk) begin
        if (cnt_clr) ack_cnt <= 0;
        else if (occ_req && occ_ack) ack_cnt <= ack_cnt + 1;
    end

    food_spawn_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_chipselect(avs_chipselect),
        .avs_write_n(avs_write_n), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .spawn_req(spawn_req), .spawn_grant(spawn_grant),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
        .coord_out(coord_out), .coord_valid(coord_valid)
    );

    function automatic logic [19:0] lfsr_step(input logic [19:0] s);
        return {1'b0, s[19:1]} ^ (s[0] ? 20'h90000 : 20'h00000);
    endfunction

    // Walks the LFSR from start until the need-th in-range candidate
    function automatic void find_cand(input logic [19:0] start, input int need,
                                      output logic [19:0] coord, output int rej, output logic [19:0] fin);
        logic [19:0] s;
        int got;
        s = start; rej = 0; got = 0; coord = 20'd0; fin = start;
        for (int i = 0; i < 200; i++) begin
            if (s[19:10] < 10'd640 && s[9:0] < 10'd480) begin
                got++;
                if (got == need) begin
                    coord = s;
                    fin = lfsr_step(s);
                    break;
                end
            end else begin
                rej++;
            end
            s = lfsr_step(s);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_chipselect = 1'b1; avs_write_n = 1'b0;
        tick;
        avs_chipselect = 1'b0; avs_write_n = 1'b1;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_chipselect = 1'b1;
        #1;
        d = avs_readdata;
        avs_chipselect = 1'b0;
    endtask

    task automatic pulse_req(input logic [1:0] r);
        spawn_req = r;
        tick;
        spawn_req = 2'b00;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    task automatic wait_done(output int cyc, output logic [1:0] g, output logic cv, output logic ok);
        ok = 1'b0; cyc = 0; g = 2'b00; cv = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick;
            cyc++;
            if (coord_valid || spawn_grant != 2'b00) begin
                g = spawn_grant; cv = coord_valid; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        do_reset;
        checks++; if (coord_out !== 20'd0) begin errors++; $display("FAIL reset_coord: got %h expected 0", coord_out); end
        checks++; if (occ_req !== 1'b0) begin errors++; $display("FAIL reset_occ_req: got %b expected 0", occ_req); end
        checks++; if ({spawn_grant, coord_valid} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {spawn_grant, coord_valid}); end
        avs_rd(2'd0, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
        avs_rd(2'd1, rd);
        checks++; if (rd !== 32'h00001) begin errors++; $display("FAIL reset_seed: got %h expected 00001", rd); end
        avs_rd(2'd2, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_coord_reg: got %h expected 0", rd); end
        avs_rd(2'd3, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected 0", rd); end
    endtask

    task automatic test_latency;
        logic [19:0] c, f;
        logic [31:0] rd;
        logic [1:0]  g;
        logic        cv, ok;
        int          r, cyc;
        avs_wr(2'd1, 32'h12345);
        avs_wr(2'd0, 32'h1);
        find_cand(20'h12345, 1, c, r, f);
        pulse_req(2'b01);
        wait_done(cyc, g, cv, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lat_timeout: got %b expected 1", ok); end
        checks++; if (cyc !== 3 + r) begin errors++; $display("FAIL lat_cycles: got %0d expected %0d", cyc, 3 + r); end
        checks++; if ({g, cv} !== 3'b011) begin errors++; $display("FAIL lat_grant: got %b expected 011", {g, cv}); end
        checks++; if (coord_out !== c) begin errors++; $display("FAIL lat_coord: got %h expected %h", coord_out, c); end
        tick;
        checks++; if ({spawn_grant, coord_valid} !== 3'b000) begin errors++; $display("FAIL lat_one_cycle: got %b expected 000", {spawn_grant, coord_valid}); end
        avs_rd(2'd1, rd);
        checks++; if (rd[19:0] !== f) begin errors++; $display("FAIL lat_lfsr_adv: got %h expected %h", rd[19:0], f); end
        avs_rd(2'd3, rd);
        checks++; if (rd[15:8] !== 8'(r)) begin errors++; $display("FAIL lat_retry: got %0d expected %0d", rd[15:8], r); end
        last_coord = c;
    endtask

    task automatic test_back_to_back;
        logic [19:0] c1, c2, c3, c4, f1, f2, f3, f4;
        logic [1:0]  g;
        logic        cv, ok;
        int          r, cyc;
        do_reset;
        avs_wr(2'd1, 32'h0ACE1);
        avs_wr(2'd0, 32'h1);
        find_cand(20'h0ACE1, 1, c1, r, f1);
        find_cand(f1, 1, c2, r, f2);
        find_cand(f2, 1, c3, r, f3);
        find_cand(f3, 1, c4, r, f4);
        pulse_req(2'b11);
        wait_done(cyc, g, cv, ok);
        checks++; if ({ok, g, cv, coord_out} !== {1'b1, 2'b01, 1'b1, c1}) begin errors++; $display("FAIL b2b_first: got g=%b c=%h expected g=01 c=%h", g, coord_out, c1); end
        wait_done(cyc, g, cv, ok);
        checks++; if ({ok, g, cv, coord_out} !== {1'b1, 2'b10, 1'b1, c2}) begin errors++; $display("FAIL b2b_second: got g=%b c=%h expected g=10 c=%h", g, coord_out, c2); end
        pulse_req(2'b11);
        wait_done(cyc, g, cv, ok);
        checks++; if ({ok, g, cv, coord_out} !== {1'b1, 2'b01, 1'b1, c3}) begin errors++; $display("FAIL b2b_rr_repeat: got g=%b c=%h expected g=01 c=%h", g, coord_out, c3); end
        wait_done(cyc, g, cv, ok);
        checks++; if ({ok, g, cv, coord_out} !== {1'b1, 2'b10, 1'b1, c4}) begin errors++; $display("FAIL b2b_rr_second: got g=%b c=%h expected g=10 c=%h", g, coord_out, c4); end
        last_coord = c4;
    endtask

    task automatic test_sw_trigger;
        logic [19:0] c, f;
        logic [31:0] rd;
        logic [1:0]  g;
        logic        cv, ok;
        int          r, cyc;
        avs_wr(2'd1, 32'h33333);
        find_cand(20'h33333, 1, c, r, f);
        avs_wr(2'd0, 32'h3);
        wait_done(cyc, g, cv, ok);
        checks++; if ({ok, g, cv} !== 4'b1001) begin errors++; $display("FAIL sw_grant: got %b expected 1001", {ok, g, cv}); end
        checks++; if (coord_out !== c) begin errors++; $display("FAIL sw_coord: got %h expected %h", coord_out, c); end
        avs_rd(2'd0, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL sw_ctrl_read: got %h expected 1", rd); end
        last_coord = c;
    endtask

    task automatic test_pending_hold;
        logic [19:0] c, f;
        logic [31:0] rd;
        logic [1:0]  g;
        logic        cv, ok, seen;
        int          r, cyc;
        avs_wr(2'd1, 32'h54321);
        avs_wr(2'd0, 32'h0);
        find_cand(20'h54321, 1, c, r, f);
        pulse_req(2'b10);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (coord_valid || occ_req) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL hold_no_spawn: got %b expected 0", seen); end
        avs_rd(2'd3, rd);
        checks++; if (rd[3:0] !== 4'b1000) begin errors++; $display("FAIL hold_pending: got %b expected 1000", rd[3:0]); end
        avs_wr(2'd0, 32'h1);
        wait_done(cyc, g, cv, ok);
        checks++; if ({ok, g, cv, coord_out} !== {1'b1, 2'b10, 1'b1, c}) begin errors++; $display("FAIL hold_release: got g=%b c=%h expected g=10 c=%h", g, coord_out, c); end
        last_coord = c;
    endtask

    task automatic test_occ_hit;
        logic [19:0] c, f;
        logic [31:0] rd;
        logic [1:0]  g;
        logic        cv, ok;
        int          r, cyc;
        avs_wr(2'd1, 32'h5A5A5);
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        hit_n = 3;
        find_cand(20'h5A5A5, 4, c, r, f);
        pulse_req(2'b01);
        wait_done(cyc, g, cv, ok);
        checks++; if ({ok, g, cv} !== 4'b1011) begin errors++; $display("FAIL hit_grant: got %b expected 1011", {ok, g, cv}); end
        checks++; if (coord_out !== c) begin errors++; $display("FAIL hit_coord: got %h expected %h", coord_out, c); end
        avs_rd(2'd3, rd);
        checks++; if (rd[15:8] !== 8'(r + 3)) begin errors++; $display("FAIL hit_retry: got %0d expected %0d", rd[15:8], r + 3); end
        hit_n = 0;
        last_coord = c;
    endtask

    task automatic test_retry_limit;
        logic [31:0] rd;
        logic [1:0]  g;
        logic        cv, ok;
        int          cyc;
        hit_all = 1'b1;
        avs_wr(2'd1, 32'h0F0F0);
        pulse_req(2'b10);
        wait_done(cyc, g, cv, ok);
        checks++; if ({ok, g, cv} !== 4'b1100) begin errors++; $display("FAIL fail_grant: got %b expected 1100", {ok, g, cv}); end
        checks++; if (coord_out !== last_coord) begin errors++; $display("FAIL fail_coord_kept: got %h expected %h", coord_out, last_coord); end
        avs_rd(2'd3, rd);
        checks++; if (rd[1] !== 1'b1) begin errors++; $display("FAIL fail_flag_set: got %b expected 1", rd[1]); end
        hit_all = 1'b0;
        avs_wr(2'd3, 32'h0);
        avs_rd(2'd3, rd);
        checks++; if (rd[1] !== 1'b0) begin errors++; $display("FAIL fail_flag_clear: got %b expected 0", rd[1]); end
    endtask

    task automatic test_delayed_ack;
        logic [19:0] c, f;
        logic [31:0] rd;
        int          r;
        ack_tie = 1'b0;
        ack_man = 1'b0;
        avs_wr(2'd1, 32'h2468A);
        find_cand(20'h2468A, 1, c, r, f);
        pulse_req(2'b01);
        for (int i = 0; i < 200 && !occ_req; i++) tick;
        checks++; if ({occ_req, occ_x, occ_y} !== {1'b1, c}) begin errors++; $display("FAIL dly_query: got %b %h expected 1 %h", occ_req, {occ_x, occ_y}, c); end
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++; if ({occ_req, occ_x, occ_y} !== {1'b1, c}) begin errors++; $display("FAIL dly_stable: got %b %h expected 1 %h", occ_req, {occ_x, occ_y}, c); end
        end
        ack_man = 1'b1;
        tick;
        ack_man = 1'b0;
        checks++; if ({coord_valid, coord_out} !== {1'b1, c}) begin errors++; $display("FAIL dly_publish: got %b %h expected 1 %h", coord_valid, coord_out, c); end
        pulse_req(2'b10);
        for (int i = 0; i < 200 && !occ_req; i++) tick;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (occ_req !== 1'b0) begin errors++; $display("FAIL rst_drop_occ_req: got %b expected 0", occ_req); end
        checks++; if (coord_out !== 20'd0) begin errors++; $display("FAIL rst_coord: got %h expected 0", coord_out); end
        avs_rd(2'd1, rd);
        checks++; if (rd !== 32'h00001) begin errors++; $display("FAIL rst_seed: got %h expected 00001", rd); end
        tick;
        reset_n = 1'b1;
        ack_tie = 1'b1;
    endtask

    initial begin
        test_reset;
        test_latency;
        test_back_to_back;
        test_sw_trigger;
        test_pending_hold;
        test_occ_hit;
        test_retry_limit;
        test_delayed_ack;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
